icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 8, sets per way; power of two, 2..64.
REQ-003 SHALL have parameter BLKWORDS, default 2, 32-bit words per block; legal values 1, 2, 4.
REQ-004 SHALL have port CLK, in, 1, rising-edge clock.
REQ-005 SHALL have port RST, in, 1, synchronous active-high reset sampled on rising CLK.
REQ-006 SHALL have datapath-side inputs: imemREN in 1 fetch request; imemaddr in 32 fetch address; dmemREN in 1; dmemWEN in 1; halt in 1.
REQ-007 SHALL have datapath-side outputs: ihit out 1 instruction valid this cycle; imemload out 32 instruction word.
REQ-008 SHALL have memory-side ports: iREN out 1 refill read; iaddr out 32 refill word address; iwait in 1 memory busy; iload in 32 refill data.

Function
REQ-009 Address split: byte offset [1:0], word offset next log2(BLKWORDS) bits, index next log2(SETS) bits, tag all remaining upper bits.
REQ-010 Each line SHALL hold valid, tag and BLKWORDS data words; each set SHALL hold a victim pointer of log2(WAYS) bits (zero-width when WAYS=1).
REQ-011 Lookup SHALL be combinational: a request is active when imemREN=1, dmemREN=0, dmemWEN=0, halt=0, and FSM is IDLE.
REQ-012 On an active request whose tag matches a valid way of the indexed set, ihit=1 and imemload=the addressed word, in the same cycle.
REQ-013 At all other times, ihit=0 and imemload=0.
REQ-014 FSM states: IDLE, FILL.
REQ-015 IDLE->FILL on an active request that misses: latch the block-aligned address and the victim way, and clear the word counter.
REQ-016 Victim selection: the lowest-numbered invalid way; if all ways are valid, the set's victim pointer.
REQ-017 In FILL: iREN=1 and iaddr=block base + 4*counter, except that iREN=0 and iaddr=0 while dmemREN or dmemWEN is high. The counter is held during that pause.
REQ-018 In FILL: on each cycle with iREN=1 and iwait=0, store iload into the victim line at counter, then increment the counter.
REQ-019 On the last word (counter=BLKWORDS-1) accepted: write the tag, set valid, advance the victim pointer mod WAYS only if all ways were valid, and go to IDLE. The re-presented request hits on the next cycle; minimum miss penalty is BLKWORDS+1 cycles.
REQ-020 halt=1 in FILL SHALL abort the fill: go to IDLE, leave valid and tag unchanged, deassert iREN that cycle.
REQ-021 In IDLE, iREN=0 and iaddr=0.
REQ-022 A change of imemaddr during FILL SHALL NOT alter the latched fill address; the fill completes, then the new address is looked up.
REQ-023 Data words SHALL be written only in FILL; no write path from the datapath exists.

Reset
REQ-024 RST=1 SHALL, at the next rising CLK, clear all valid bits, tags, data and victim pointers, force FSM to IDLE and the counter to 0.
REQ-025 RST asserted mid-fill SHALL discard the partial line. Outputs during and after reset: ihit=0, imemload=0, iREN=0, iaddr=0.

Configuration
REQ-026 Macro ICACHE_PERF_EN defined SHALL add outputs hit_count (out, 32) and miss_count (out, 32).
REQ-027 With ICACHE_PERF_EN, hit_count increments on every cycle with ihit=1, and miss_count increments on every IDLE->FILL transition. Both wrap at 2^32, and both clear on RST.
REQ-028 Without ICACHE_PERF_EN, these ports and counters SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-029 Cold miss, default params: RST, then fetch 0x00000040 with iwait=0 and iload=0xAAAA0001, then 0xAAAA0002. Required: iaddr 0x40 then 0x44, ihit=1 with imemload=0xAAAA0001 three cycles after the request.
REQ-030 Spatial hit: after REQ-029, fetch 0x00000044. Required: ihit=1 the same cycle, imemload=0xAAAA0002, iREN=0.
REQ-031 Conflict and replacement: fill 0x040, 0x140, then 0x240 (same index). Required: the third fill evicts way 0, 0x140 still hits, 0x040 misses.
REQ-032 Pause and abort: during FILL raise dmemREN for 3 cycles; iREN=0 and the counter is held, then the fill resumes at the same word. A separate fill aborted by halt=1 leaves that line invalid; a refetch misses.
REQ-033 ICACHE_PERF_EN: run REQ-029 and REQ-030. Required: hit_count=2, miss_count=1; RST returns both to 0.

Source files
------------

// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side signal bundle of the instruction cache.
// slave is the cache end; master is the datapath/memory end.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, halt, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with word-by-word block refill.
// Define ICACHE_PERF_EN to add the hit_count / miss_count performance counters.
module icache_assoc #(
  parameter int unsigned WAYS     = 2,
  parameter int unsigned SETS     = 8,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic          CLK,
  input  logic          RST,
  icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);
  localparam int unsigned WOFF = $clog2(BLKWORDS);
  localparam int unsigned WB   = (BLKWORDS > 1) ? WOFF : 1;
  localparam int unsigned IB   = $clog2(SETS);
  localparam int unsigned TAGW = 30 - WOFF - IB;
  localparam int unsigned VB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {StIdle, StFill} state_e;
  state_e state_q, state_d;

  logic            valid_q  [WAYS][SETS];
  logic [TAGW-1:0] tag_q    [WAYS][SETS];
  logic [31:0]     data_q   [WAYS][SETS][BLKWORDS];
  logic [VB-1:0]   victim_q [SETS];

  logic [TAGW-1:0] fill_tag_q;
  logic [IB-1:0]   fill_idx_q;
  logic [VB-1:0]   fill_way_q;
  logic            fill_full_q;
  logic [WB-1:0]   cnt_q;

  logic [TAGW-1:0] req_tag;
  logic [IB-1:0]   req_idx;
  logic [WB-1:0]   req_word;
  logic            active, hit, all_valid, accept, last, start_fill;
  logic [VB-1:0]   hit_way, vict_way;
  logic [31:0]     fill_base;
  logic            unused_addr;

  assign req_tag     = bus.imemaddr[31 -: TAGW];
  assign req_idx     = bus.imemaddr[2 + WOFF +: IB];
  assign req_word    = (BLKWORDS > 1) ? bus.imemaddr[2 +: WB] : '0;
  assign unused_addr = ^bus.imemaddr[1:0];

  assign active = bus.imemREN & ~bus.dmemREN & ~bus.dmemWEN & ~bus.halt & ~RST &
                  (state_q == StIdle);
  assign fill_base  = {fill_tag_q, fill_idx_q, {(WOFF + 2){1'b0}}};
  assign accept     = bus.iREN & ~bus.iwait;
  assign last       = (cnt_q == WB'(BLKWORDS - 1));
  assign start_fill = (state_q == StIdle) && (state_d == StFill);

  // Descending scan so the lowest-numbered invalid way wins as victim.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    all_valid = 1'b1;
    vict_way  = victim_q[req_idx];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        all_valid = 1'b0;
        vict_way  = VB'(w);
      end
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = VB'(w);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (active && !hit) state_d = StFill;
      StFill:  if (bus.halt || (accept && last)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    if (active && hit) begin
      bus.ihit     = 1'b1;
      bus.imemload = data_q[hit_way][req_idx][req_word];
    end
    // Refill yields the bus to data accesses and stops at once on halt or reset.
    if ((state_q == StFill) && !RST && !bus.dmemREN && !bus.dmemWEN && !bus.halt) begin
      bus.iREN  = 1'b1;
      bus.iaddr = fill_base | (32'(cnt_q) << 2);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          for (int b = 0; b < int'(BLKWORDS); b++) data_q[w][s][b] <= '0;
        end
      end
      for (int s = 0; s < int'(SETS); s++) victim_q[s] <= '0;
      fill_tag_q  <= '0;
      fill_idx_q  <= '0;
      fill_way_q  <= '0;
      fill_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (start_fill) begin
        fill_tag_q  <= req_tag;
        fill_idx_q  <= req_idx;
        fill_way_q  <= vict_way;
        fill_full_q <= all_valid;
        cnt_q       <= '0;
      end
      if (accept) begin
        data_q[fill_way_q][fill_idx_q][cnt_q] <= bus.iload;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          tag_q[fill_way_q][fill_idx_q]   <= fill_tag_q;
          valid_q[fill_way_q][fill_idx_q] <= 1'b1;
          // Pointer only rotates when a valid line was actually displaced.
          if (fill_full_q) begin
            victim_q[fill_idx_q] <= (WAYS > 1) ? victim_q[fill_idx_q] + 1'b1 : '0;
          end
        end
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit)  hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: directed scenarios plus random fetches
// against a set/way reference model; a monitor checks every DUT output cycle.
module tb_icache_assoc;
  localparam int unsigned WAYS     = 2;
  localparam int unsigned SETS     = 8;
  localparam int unsigned BLKWORDS = 2;
  localparam int unsigned BLKBYTES = 4 * BLKWORDS;

  logic CLK = 1'b0;
  logic RST;
  icache_assoc_if bus ();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BLKWORDS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit rand_wait = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  bit          m_valid[WAYS][SETS];
  int unsigned m_tag[WAYS][SETS];
  int unsigned m_ptr[SETS];

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic int unsigned set_of(logic [31:0] a);
    return (a / BLKBYTES) % SETS;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return a / (BLKBYTES * SETS);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    for (int w = 0; w < int'(WAYS); w++)
      if (m_valid[w][set_of(a)] && m_tag[w][set_of(a)] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(logic [31:0] a);
    int unsigned s;
    int v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < int'(WAYS); w++) if (v < 0 && !m_valid[w][s]) v = w;
    if (v < 0) begin
      v = int'(m_ptr[s]);
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[v][s] = 1'b1;
    m_tag[v][s]   = tag_of(a);
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[w][s] = 1'b0;
        m_tag[w][s]   = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory side: data follows the requested address, iwait is optionally random.
  always_comb bus.iload = mem_fn(bus.iaddr);

  initial begin
    bus.iwait = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      bus.iwait = rand_wait && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: consumes expected words on hits and expected refill addresses.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (bus.ihit) begin
          chk("hit_iren", {31'd0, bus.iREN}, 32'd0);
          if (exp_q.size() == 0) fail_now("unexpected_hit");
          else begin
            e = exp_q.pop_front();
            chk("imemload", bus.imemload, e);
          end
        end else begin
          chk("load_idle", bus.imemload, 32'd0);
        end
        if (bus.iREN && !bus.iwait) begin
          if (addr_q.size() == 0) fail_now("unexpected_refill");
          else begin
            e = addr_q.pop_front();
            chk("iaddr", bus.iaddr, e);
          end
        end else if (!bus.iREN) begin
          chk("iaddr_idle", bus.iaddr, 32'd0);
        end
      end
    end
  end

  task automatic expect_fill(input logic [31:0] a);
    logic [31:0] base;
    base = a - (a % BLKBYTES);
    for (int w = 0; w < int'(BLKWORDS); w++) addr_q.push_back(base + 32'(4 * w));
    m_fill(a);
  endtask

  task automatic wait_hit(output int cyc);
    cyc = 0;
    while (!bus.ihit && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
    if (!bus.ihit) begin
      fail_now("hit_timeout");
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic fetch(input logic [31:0] a, output bit hit0);
    bit exp_hit;
    int cyc;
    exp_hit = m_hit(a);
    if (!exp_hit) expect_fill(a);
    exp_q.push_back(mem_fn(a));
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    @(negedge CLK);
    hit0 = bus.ihit;
    chk("hit_first", {31'd0, hit0}, {31'd0, exp_hit});
    wait_hit(cyc);
    if (!exp_hit && !rand_wait) chk("miss_latency", cyc, BLKWORDS + 1);
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
  endtask

  task automatic fetch_pause(input logic [31:0] a);
    int cyc;
    expect_fill(a);
    exp_q.push_back(mem_fn(a));
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    bus.dmemREN = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("pause_iren", {31'd0, bus.iREN}, 32'd0);
      chk("pause_iaddr", bus.iaddr, 32'd0);
      @(posedge CLK); #1;
    end
    bus.dmemREN = 1'b0;
    @(negedge CLK);
    wait_hit(cyc);
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
  endtask

  task automatic fetch_abort(input logic [31:0] a);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    @(negedge CLK);
    chk("abort_first_miss", {31'd0, bus.ihit}, 32'd0);
    @(posedge CLK); #1;
    bus.halt    = 1'b1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    chk("abort_iren", {31'd0, bus.iREN}, 32'd0);
    @(posedge CLK); #1;
    bus.halt = 1'b0;
  endtask

  task automatic check_perf(input logic [31:0] hits, input logic [31:0] misses);
`ifdef ICACHE_PERF_EN
    chk("hit_count", hit_count, hits);
    chk("miss_count", miss_count, misses);
`else
    if (hits != misses) ; // counters absent in this build
`endif
  endtask

  initial begin
    bit h;
    logic [31:0] a;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.dmemREN  = 1'b0;
    bus.dmemWEN  = 1'b0;
    bus.halt     = 1'b0;
    RST          = 1'b1;
    m_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    check_perf(32'd0, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    bus.imemREN = 1'b0;
    mon_en = 1'b1;

    // Cold miss then spatial hit in the same block.
    fetch(32'h40, h);
    chk("cold_miss", {31'd0, h}, 32'd0);
    fetch(32'h44, h);
    chk("spatial_hit", {31'd0, h}, 32'd1);
    check_perf(32'd2, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    m_reset();
    check_perf(32'd0, 32'd0);

    // Three blocks mapping to set 0: third evicts way 0.
    fetch(32'h040, h);
    fetch(32'h140, h);
    fetch(32'h240, h);
    fetch(32'h140, h);
    chk("conflict_keep", {31'd0, h}, 32'd1);
    fetch(32'h040, h);
    chk("conflict_evict", {31'd0, h}, 32'd0);

    // Data-side pause in mid-fill, then halt abort leaving the line invalid.
    fetch_pause(32'h300);
    fetch_abort(32'h388);
    fetch(32'h388, h);
    chk("abort_refetch", {31'd0, h}, 32'd0);

    // Reset during a fill discards everything.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h500;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("midrst_ihit", {31'd0, bus.ihit}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    bus.imemREN = 1'b0;
    m_reset();
    fetch(32'h140, h);
    chk("after_rst_miss", {31'd0, h}, 32'd0);

    // Random fetches with random memory stalls and data-side collisions.
    rand_wait = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 7) == 0) begin
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        if ($urandom_range(0, 1) == 1) bus.dmemREN = 1'b1;
        else                           bus.dmemWEN = 1'b1;
        @(negedge CLK);
        chk("dmem_blocks_hit", {31'd0, bus.ihit}, 32'd0);
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
      end
      fetch(a, h);
    end

    @(negedge CLK);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
